read_arbiter: RTL and testbench

- Shares the read port of one image memory-pool group among three requesters: conv, misc and save (the dataloader store path).
- Arbitrates one request per cycle and registers the winner's bank_en/addr onto the RAM read port.
- Tracks each in-flight read with an owner tag so the returning data is steered back to the requester that issued it.
- Sticky priority with a hold limit, so no requester can starve the others; it is the read-side companion to the group's write arbiter.

---
 rtl/mem_pool_pkg.sv | 34 +++
 rtl/read_tag_pipe.sv | 29 ++
 rtl/read_arbiter.sv | 171 +++++++++++++++++
 tb/tb_read_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pool_pkg.sv
// rtl/mem_pool_pkg.sv - owner encoding and rotation helper shared by the memory-pool arbiters
package mem_pool_pkg;

    localparam logic [2:0] NONE_USE = 3'b000;
    localparam logic [2:0] CONV_USE = 3'b001;
    localparam logic [2:0] MISC_USE = 3'b010;
    localparam logic [2:0] SAVE_USE = 3'b100;

    // First valid requester after owner_i in CONV->MISC->SAVE->CONV order, owner_i itself excluded.
    function automatic logic [2:0] next_in_rotation(
        input logic [2:0] owner_i,
        input logic [2:0] valid_i
    );
        logic [2:0] next_owner;
        next_owner = NONE_USE;
        case (owner_i)
            CONV_USE: begin
                if (valid_i[1])      next_owner = MISC_USE;
                else if (valid_i[2]) next_owner = SAVE_USE;
            end
            MISC_USE: begin
                if (valid_i[2])      next_owner = SAVE_USE;
                else if (valid_i[0]) next_owner = CONV_USE;
            end
            SAVE_USE: begin
                if (valid_i[0])      next_owner = CONV_USE;
                else if (valid_i[1]) next_owner = MISC_USE;
            end
            default: next_owner = NONE_USE;
        endcase
        return next_owner;
    endfunction

endpackage

// File: rtl/read_tag_pipe.sv
// rtl/read_tag_pipe.sv - fixed-depth shift register carrying {valid, owner} tags beside the RAM
module read_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic [WIDTH-1:0] tag_i,
    output logic [WIDTH-1:0] tag_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst_p) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/read_arbiter.sv
// rtl/read_arbiter.sv - three-way read-port arbiter for one memory-pool group
// Sticky priority with a hold limit; owner tags steer returning RAM data back to the issuer.
module read_arbiter
    import mem_pool_pkg::*;
#(
    parameter int ROW_PARA    = 4,
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 256,
    parameter int RAM_LATENCY = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                  clk,
    input  logic                  rst_p,

    input  logic                  conv_read_valid_i,
    input  logic [ROW_PARA-1:0]   conv_read_bank_en_i,
    input  logic [ADDR_WIDTH-1:0] conv_read_addr_i,
    output logic                  conv_read_ready_o,
    output logic [DATA_WIDTH-1:0] conv_read_data_o,
    output logic                  conv_read_data_valid_o,

    input  logic                  misc_read_valid_i,
    input  logic [ROW_PARA-1:0]   misc_read_bank_en_i,
    input  logic [ADDR_WIDTH-1:0] misc_read_addr_i,
    output logic                  misc_read_ready_o,
    output logic [DATA_WIDTH-1:0] misc_read_data_o,
    output logic                  misc_read_data_valid_o,

    input  logic                  save_read_valid_i,
    input  logic [ROW_PARA-1:0]   save_read_bank_en_i,
    input  logic [ADDR_WIDTH-1:0] save_read_addr_i,
    output logic                  save_read_ready_o,
    output logic [DATA_WIDTH-1:0] save_read_data_o,
    output logic                  save_read_data_valid_o,

    output logic                  ram_read_en_o,
    output logic [ROW_PARA-1:0]   ram_read_bank_en_o,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_read_data_i
);

    localparam int                HOLD_W     = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [2:0]            req_valid;
    logic [2:0]            grant;
    logic                  accept;
    logic [2:0]            owner_q, owner_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [ROW_PARA-1:0]   win_bank_en;
    logic [ADDR_WIDTH-1:0] win_addr;

    logic                  rd_en_q;
    logic [ROW_PARA-1:0]   rd_bank_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    logic [3:0]            tag_in, tag_out;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [2:0]            rsp_valid_q;

    assign req_valid = {save_read_valid_i, misc_read_valid_i, conv_read_valid_i};

    // The hold-limit rotation is checked first so a long-running owner yields even while still valid.
    always_comb begin
        grant = NONE_USE;
        if (rst_p) begin
            grant = NONE_USE;
        end else if ((owner_q != NONE_USE) && (hold_cnt_q == HOLD_LIMIT)
                     && ((req_valid & ~owner_q) != 3'b000)) begin
            grant = next_in_rotation(owner_q, req_valid);
        end else if ((owner_q & req_valid) != 3'b000) begin
            grant = owner_q;
        end else if (req_valid[0]) begin
            grant = CONV_USE;
        end else if (req_valid[1]) begin
            grant = MISC_USE;
        end else if (req_valid[2]) begin
            grant = SAVE_USE;
        end
    end

    assign accept = (grant != NONE_USE);

    always_comb begin
        win_bank_en = '0;
        win_addr    = '0;
        case (grant)
            CONV_USE: begin
                win_bank_en = conv_read_bank_en_i;
                win_addr    = conv_read_addr_i;
            end
            MISC_USE: begin
                win_bank_en = misc_read_bank_en_i;
                win_addr    = misc_read_addr_i;
            end
            SAVE_USE: begin
                win_bank_en = save_read_bank_en_i;
                win_addr    = save_read_addr_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_d    = grant;
        hold_cnt_d = '0;
        if (accept && (grant == owner_q)) begin
            hold_cnt_d = (hold_cnt_q == HOLD_LIMIT) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            owner_q      <= NONE_USE;
            hold_cnt_q   <= '0;
            rd_en_q      <= 1'b0;
            rd_bank_en_q <= '0;
            rd_addr_q    <= '0;
        end else begin
            owner_q      <= owner_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_en_q      <= accept;
            rd_bank_en_q <= accept ? win_bank_en : '0;
            if (accept) begin
                rd_addr_q <= win_addr;
            end
        end
    end

    // owner_q is exactly the owner of the read currently on the RAM port whenever rd_en_q is high.
    assign tag_in = {rd_en_q, owner_q};

    read_tag_pipe #(
        .DEPTH (RAM_LATENCY),
        .WIDTH (4)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_p (rst_p),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_ff @(posedge clk) begin
        if (rst_p) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= 3'b000;
        end else begin
            rsp_valid_q <= tag_out[3] ? tag_out[2:0] : 3'b000;
            if (tag_out[3]) begin
                rsp_data_q <= ram_read_data_i;
            end
        end
    end

    assign conv_read_ready_o      = grant[0];
    assign misc_read_ready_o      = grant[1];
    assign save_read_ready_o      = grant[2];

    assign conv_read_data_o       = rsp_data_q;
    assign misc_read_data_o       = rsp_data_q;
    assign save_read_data_o       = rsp_data_q;

    assign conv_read_data_valid_o = rsp_valid_q[0];
    assign misc_read_data_valid_o = rsp_valid_q[1];
    assign save_read_data_valid_o = rsp_valid_q[2];

    assign ram_read_en_o          = rd_en_q;
    assign ram_read_bank_en_o     = rd_bank_en_q;
    assign ram_read_addr_o        = rd_addr_q;

endmodule

// File: tb/tb_read_arbiter.sv
// tb/tb_read_arbiter.sv - self-checking bench for read_arbiter with a behavioural grant/response model
module tb_read_arbiter;

    localparam int ROW_PARA    = 4;
    localparam int ADDR_WIDTH  = 48;
    localparam int DATA_WIDTH  = 256;
    localparam int RAM_LATENCY = 2;
    localparam int MAX_HOLD    = 16;
    localparam int RSP_DELAY   = 2 + RAM_LATENCY;

    logic clk = 1'b0;
    logic rst_p;
    always #5 clk = ~clk;

    logic                  v  [3];
    logic [ROW_PARA-1:0]   be [3];
    logic [ADDR_WIDTH-1:0] ad [3];

    wire [2:0]            rdy;
    wire [2:0]            dvld;
    wire [DATA_WIDTH-1:0] dat0, dat1, dat2;
    wire                  ram_en;
    wire [ROW_PARA-1:0]   ram_be;
    wire [ADDR_WIDTH-1:0] ram_ad;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [DATA_WIDTH-1:0] rpipe [RAM_LATENCY];

    read_arbiter #(
        .ROW_PARA    (ROW_PARA),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .RAM_LATENCY (RAM_LATENCY),
        .MAX_HOLD    (MAX_HOLD)
    ) dut (
        .clk                    (clk),
        .rst_p                  (rst_p),
        .conv_read_valid_i      (v[0]),
        .conv_read_bank_en_i    (be[0]),
        .conv_read_addr_i       (ad[0]),
        .conv_read_ready_o      (rdy[0]),
        .conv_read_data_o       (dat0),
        .conv_read_data_valid_o (dvld[0]),
        .misc_read_valid_i      (v[1]),
        .misc_read_bank_en_i    (be[1]),
        .misc_read_addr_i       (ad[1]),
        .misc_read_ready_o      (rdy[1]),
        .misc_read_data_o       (dat1),
        .misc_read_data_valid_o (dvld[1]),
        .save_read_valid_i      (v[2]),
        .save_read_bank_en_i    (be[2]),
        .save_read_addr_i       (ad[2]),
        .save_read_ready_o      (rdy[2]),
        .save_read_data_o       (dat2),
        .save_read_data_valid_o (dvld[2]),
        .ram_read_en_o          (ram_en),
        .ram_read_bank_en_o     (ram_be),
        .ram_read_addr_o        (ram_ad),
        .ram_read_data_i        (ram_data)
    );

    function automatic logic [DATA_WIDTH-1:0] ram_word(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [ROW_PARA-1:0] b);
        logic [DATA_WIDTH-1:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k*64 +: 64] = {a ^ (48'h9E37_79B9_7F4A * 48'(k + 1)), 12'hA50 + 12'(k), b};
        end
        return w;
    endfunction

    // RAM: data for a read strobed in cycle c is presented in cycle c+RAM_LATENCY; noise otherwise.
    always @(posedge clk) begin
        rpipe[0] <= ram_en ? ram_word(ram_ad, ram_be) : {8{32'($urandom)}};
        for (int k = 1; k < RAM_LATENCY; k++) rpipe[k] <= rpipe[k-1];
    end
    assign ram_data = rpipe[RAM_LATENCY-1];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [DATA_WIDTH-1:0] act,
                         input logic [DATA_WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Grant rule from run length: after MAX_HOLD consecutive grants a waiting other requester wins,
    // chosen in rotation order; otherwise the previous owner sticks, else CONV > MISC > SAVE.
    function automatic int model_grant(input int last, input int run, input logic [2:0] vv);
        bit others;
        others = 1'b0;
        for (int k = 0; k < 3; k++) if (k != last && vv[k]) others = 1'b1;
        if (last >= 0 && run >= MAX_HOLD && others) begin
            for (int k = 1; k < 3; k++) if (vv[(last + k) % 3]) return (last + k) % 3;
        end
        if (last >= 0) begin
            if (vv[last]) return last;
        end
        for (int k = 0; k < 3; k++) if (vv[k]) return k;
        return -1;
    endfunction

    typedef struct {
        int                    owner;
        int                    due;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    rsp_t                  rq [$];
    bit                    m_ok   = 1'b0;
    int                    m_last = -1;
    int                    m_run  = 0;
    logic                  m_en;
    logic [ROW_PARA-1:0]   m_be;
    logic [ADDR_WIDTH-1:0] m_ad;
    logic [DATA_WIDTH-1:0] m_data;

    always @(negedge clk) begin
        logic [2:0]            vv, exp_rdy, exp_dv;
        logic [DATA_WIDTH-1:0] exp_data;
        int                    g;
        vv      = {v[2], v[1], v[0]};
        g       = rst_p ? -1 : model_grant(m_last, m_run, vv);
        exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
        if (m_ok) begin
            check("ready", rdy, exp_rdy);
            check("ram_en", ram_en, m_en);
            check("ram_bank_en", ram_be, m_be);
            check("ram_addr", ram_ad, m_ad);
            exp_dv   = 3'b000;
            exp_data = m_data;
            if (rq.size() > 0) begin
                if (rq[0].due == cyc) begin
                    exp_dv   = 3'(1 << rq[0].owner);
                    exp_data = rq[0].data;
                end
            end
            check("data_valid", dvld, exp_dv);
            check("conv_data", dat0, exp_data);
            check("misc_data", dat1, exp_data);
            check("save_data", dat2, exp_data);
            if (exp_dv != 3'b000) begin
                m_data = exp_data;
                void'(rq.pop_front());
            end
        end
        if (rst_p) begin
            m_ok = 1'b1; m_last = -1; m_run = 0;
            m_en = 1'b0; m_be = '0; m_ad = '0; m_data = '0;
            rq.delete();
        end else if (m_ok) begin
            m_en = (g >= 0);
            m_be = '0;
            if (g >= 0) begin
                m_be  = be[g];
                m_ad  = ad[g];
                rq.push_back('{owner: g, due: cyc + RSP_DELAY, data: ram_word(ad[g], be[g])});
                m_run = (g == m_last) ? m_run + 1 : 1;
            end else begin
                m_run = 0;
            end
            m_last = g;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit         acc [3];
    logic [2:0] seq [6];
    int         pulses, conv_run, conv_pulses, load;

    initial begin
        rst_p = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; be[i] = '0; ad[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_p = 1'b0;

        // single conv read
        v[0] = 1'b1; ad[0] = 48'h10; be[0] = 4'b0011;
        @(negedge clk);
        check("t1_conv_ready", rdy, 3'b001);
        step();
        v[0] = 1'b0;
        @(negedge clk);
        check("t1_ram_en", ram_en, 1'b1);
        check("t1_ram_addr", ram_ad, 48'h10);
        check("t1_ram_bank", ram_be, 4'b0011);
        for (int k = 2; k <= 4; k++) begin
            step();
            @(negedge clk);
            check("t1_data_valid", dvld, (k == 4) ? 3'b001 : 3'b000);
        end
        check("t1_data", dat0, ram_word(48'h10, 4'b0011));

        // simultaneous from idle
        step();
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b1; ad[i] = 48'h200 + 48'(i); be[i] = 4'(1 << i);
        end
        @(negedge clk); check("t2_first", rdy, 3'b001);
        step(); v[0] = 1'b0;
        @(negedge clk); check("t2_second", rdy, 3'b010);
        step(); v[1] = 1'b0;
        @(negedge clk); check("t2_third", rdy, 3'b100);
        step(); v[2] = 1'b0;

        // hold limit
        repeat (6) step();
        v[0] = 1'b1; v[1] = 1'b1; ad[1] = 48'h300; be[1] = 4'hF; be[0] = 4'h1;
        conv_run = 0;
        for (int k = 0; k < 16; k++) begin
            ad[0] = 48'h400 + 48'(k);
            @(negedge clk);
            if (rdy == 3'b001) conv_run++;
            step();
        end
        @(negedge clk);
        check("t3_conv_run", conv_run, 16);
        check("t3_forced_switch", rdy, 3'b010);
        step(); v[1] = 1'b0;
        @(negedge clk); check("t3_conv_back", rdy, 3'b001);
        step(); v[0] = 1'b0;

        // misc/save interleave
        repeat (6) step();
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            v[1] = (k < 6) && (k % 2 == 0); ad[1] = 48'h500 + 48'(k); be[1] = 4'h4;
            v[2] = (k < 6) && (k % 2 == 1); ad[2] = 48'h600 + 48'(k); be[2] = 4'h8;
            @(negedge clk);
            if (dvld != 3'b000) begin
                if (pulses < 6) seq[pulses] = dvld;
                pulses++;
            end
            step();
        end
        check("t4_pulses", pulses, 6);
        for (int j = 0; j < 6; j++) check("t4_order", seq[j], (j % 2 == 0) ? 3'b010 : 3'b100);

        // reset with reads in flight
        v[1] = 1'b0; v[2] = 1'b0;
        repeat (6) step();
        v[0] = 1'b1; be[0] = 4'h3;
        for (int k = 0; k < 3; k++) begin
            ad[0] = 48'h700 + 48'(k);
            @(negedge clk); check("t5_accept", rdy, 3'b001);
            step();
        end
        v[0] = 1'b0; rst_p = 1'b1; v[1] = 1'b1; ad[1] = 48'h800; be[1] = 4'h2;
        @(negedge clk); check("t5_ready_in_reset", rdy, 3'b000);
        step(); rst_p = 1'b0;
        @(negedge clk);
        check("t5_ram_en", ram_en, 1'b0);
        check("t5_ram_bank", ram_be, 4'h0);
        check("t5_ram_addr", ram_ad, 48'h0);
        check("t5_dvalid", dvld, 3'b000);
        check("t5_data", dat0, '0);
        check("t5_misc_reissue", rdy, 3'b010);
        step(); v[1] = 1'b0;
        conv_pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dvld[0]) conv_pulses++;
            step();
        end
        check("t5_no_conv_data", conv_pulses, 0);

        // randomized traffic, heavy then light, with rare resets
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) acc[i] = v[i] && rdy[i];
            step();
            rst_p = ($urandom_range(0, 399) == 0);
            load  = (c < 700) ? 92 : 45;
            for (int i = 0; i < 3; i++) begin
                if (acc[i] || !v[i]) begin
                    if ($urandom_range(0, 99) < load) begin
                        v[i]  = 1'b1;
                        ad[i] = {16'($urandom), 32'($urandom)};
                        be[i] = 4'($urandom);
                    end else begin
                        v[i] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        rst_p = 1'b0;
        repeat (12) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
